spi_ram_arbiter: RTL and testbench

//  Owns the single-port RAM and shares it between the SPI slave command stream and a local requester.

---
 rtl/spi_ram_arbiter_pkg.sv | 20 ++
 rtl/spi_ram_arbiter_if.sv | 32 +++
 rtl/spi_ram_arbiter_rr_arb2.sv | 24 ++
 rtl/spi_ram_arbiter.sv | 104 ++++++++++
 tb/tb_spi_ram_arbiter.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_arbiter_pkg.sv
// Shared types and constants for the SPI/local RAM arbiter.
package spi_ram_pkg;

   typedef enum logic [1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

   // Requester index into the arbiter req/gnt vectors and read-return tag.
   localparam logic SRC_SPI = 1'b0;
   localparam logic SRC_LOC = 1'b1;

   typedef struct packed {
      logic vld;
      logic src;
   } rd_tag_t;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Bus bundle of the arbiter: SPI command/return, local port and RAM port.
interface spi_ram_arbiter_if #(parameter int ADDR_SIZE = 8);
   logic [9:0]           rx_data;
   logic                 rx_valid;
   logic [7:0]           tx_data;
   logic                 tx_valid;
   logic                 loc_req;
   logic                 loc_we;
   logic [ADDR_SIZE-1:0] loc_addr;
   logic [7:0]           loc_wdata;
   logic                 loc_gnt;
   logic [7:0]           loc_rdata;
   logic                 loc_rvalid;
   logic                 ram_en;
   logic                 ram_we;
   logic [ADDR_SIZE-1:0] ram_addr;
   logic [7:0]           ram_wdata;
   logic [7:0]           ram_rdata;
   logic                 err_ovf;

   modport slave (
      input  rx_data, rx_valid, loc_req, loc_we, loc_addr, loc_wdata, ram_rdata,
      output tx_data, tx_valid, loc_gnt, loc_rdata, loc_rvalid,
             ram_en, ram_we, ram_addr, ram_wdata, err_ovf
   );

   modport master (
      output rx_data, rx_valid, loc_req, loc_we, loc_addr, loc_wdata, ram_rdata,
      input  tx_data, tx_valid, loc_gnt, loc_rdata, loc_rvalid,
             ram_en, ram_we, ram_addr, ram_wdata, err_ovf
   );
endinterface

// File: rtl/spi_ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner.
module rr_arb2
   import spi_ram_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr;

   // On a tie the side that did not win last time goes first.
   always_comb begin
      gnt = req;
      if (&req) gnt = (ptr == SRC_LOC) ? 2'b01 : 2'b10;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    ptr <= SRC_LOC;
      else if (|req) ptr <= gnt[SRC_LOC];
   end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Shares one single-port RAM between the SPI command stream and a local
// requester; decodes SPI commands and routes read data back to its owner.
module spi_ram_arbiter
   import spi_ram_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   spi_ram_arbiter_if.slave   bus
);

   if (MEM_DEPTH != (1 << ADDR_SIZE)) begin : g_depth_chk
      $error("MEM_DEPTH must equal 2**ADDR_SIZE");
   end

   cmd_e                 cmd;
   logic [7:0]           payload;
   logic                 data_cmd;
   logic [ADDR_SIZE-1:0] wr_addr, rd_addr, pend_addr, spi_addr, acc_addr;
   logic                 spi_pend, pend_we, spi_we, acc_we;
   logic [7:0]           pend_data, spi_data, acc_data;
   logic [1:0]           req, gnt;
   rd_tag_t              tag_s1, tag_s2;

   assign cmd      = cmd_e'(bus.rx_data[9:8]);
   assign payload  = bus.rx_data[7:0];
   assign data_cmd = bus.rx_valid && (cmd == CMD_WR_DATA || cmd == CMD_RD_DATA);

   // A fresh data command competes in the same edge it arrives; it only
   // lands in the pending buffer if it loses.
   assign spi_we   = spi_pend ? pend_we   : (cmd == CMD_WR_DATA);
   assign spi_addr = spi_pend ? pend_addr : ((cmd == CMD_WR_DATA) ? wr_addr : rd_addr);
   assign spi_data = spi_pend ? pend_data : payload;

   assign req[SRC_SPI] = spi_pend || data_cmd;
   assign req[SRC_LOC] = bus.loc_req && !bus.loc_gnt;

   rr_arb2 u_arb (.clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt));

   always_comb begin
      acc_we   = spi_we;
      acc_addr = spi_addr;
      acc_data = spi_data;
      if (gnt[SRC_LOC]) begin
         acc_we   = bus.loc_we;
         acc_addr = bus.loc_addr;
         acc_data = bus.loc_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_addr        <= '0;
         rd_addr        <= '0;
         spi_pend       <= 1'b0;
         pend_we        <= 1'b0;
         pend_addr      <= '0;
         pend_data      <= '0;
         tag_s1         <= '0;
         tag_s2         <= '0;
         bus.err_ovf    <= 1'b0;
         bus.ram_en     <= 1'b0;
         bus.ram_we     <= 1'b0;
         bus.ram_addr   <= '0;
         bus.ram_wdata  <= '0;
         bus.loc_gnt    <= 1'b0;
         bus.tx_data    <= '0;
         bus.tx_valid   <= 1'b0;
         bus.loc_rdata  <= '0;
         bus.loc_rvalid <= 1'b0;
      end else begin
         if (bus.rx_valid && cmd == CMD_WR_ADDR) wr_addr <= payload[ADDR_SIZE-1:0];
         if (bus.rx_valid && cmd == CMD_RD_ADDR) rd_addr <= payload[ADDR_SIZE-1:0];
         if (data_cmd && spi_pend) bus.err_ovf <= 1'b1;

         if (spi_pend) begin
            if (gnt[SRC_SPI]) spi_pend <= 1'b0;
         end else if (data_cmd && !gnt[SRC_SPI]) begin
            spi_pend  <= 1'b1;
            pend_we   <= spi_we;
            pend_addr <= spi_addr;
            pend_data <= spi_data;
         end

         bus.ram_en    <= |gnt;
         bus.ram_we    <= (|gnt) && acc_we;
         bus.ram_addr  <= (|gnt) ? acc_addr : '0;
         bus.ram_wdata <= (|gnt && acc_we) ? acc_data : '0;
         bus.loc_gnt   <= gnt[SRC_LOC];

         // Tag rides alongside the access; ram_rdata is live while it sits in s2.
         tag_s1 <= '{vld: (|gnt) && !acc_we, src: gnt[SRC_LOC]};
         tag_s2 <= tag_s1;

         bus.tx_valid   <= tag_s2.vld && (tag_s2.src == SRC_SPI);
         bus.loc_rvalid <= tag_s2.vld && (tag_s2.src == SRC_LOC);
         if (tag_s2.vld && tag_s2.src == SRC_SPI) bus.tx_data   <= bus.ram_rdata;
         if (tag_s2.vld && tag_s2.src == SRC_LOC) bus.loc_rdata <= bus.ram_rdata;
      end
   end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed scenarios plus random traffic against a transaction-level model.
module tb_spi_ram_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_ram_arbiter_if #(.ADDR_SIZE(8)) bus ();

   spi_ram_arbiter #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   // RAM behind the arbiter
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
         else            bus.ram_rdata     <= mem[bus.ram_addr];
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: what each cycle must show, derived from the rules.
   typedef struct {int due; bit src; bit [7:0] d; bit k;} ret_t;
   ret_t       rq[$];
   bit [7:0]   ref_mem [256];
   bit         ref_known [256];
   int         cycn = 0;
   bit         m_pend, m_pwe, m_last;
   bit [7:0]   m_paddr, m_pdata, m_wra, m_rda;
   bit         m_ram_en, m_ram_we, m_loc_gnt, m_tx_valid, m_loc_rvalid, m_err;
   bit [7:0]   m_ram_addr, m_ram_wdata, m_tx_data, m_loc_rdata;
   bit         m_tx_known, m_lr_known;

   task automatic model_reset();
      rq.delete();
      m_pend = 0; m_pwe = 0; m_paddr = 0; m_pdata = 0; m_wra = 0; m_rda = 0;
      m_last = 1;
      m_ram_en = 0; m_ram_we = 0; m_ram_addr = 0; m_ram_wdata = 0;
      m_loc_gnt = 0; m_tx_valid = 0; m_loc_rvalid = 0; m_err = 0;
      m_tx_data = 0; m_loc_rdata = 0; m_tx_known = 1; m_lr_known = 1;
   endtask

   task automatic model_step();
      bit newcmd, s_has, l_has, any, win_loc, we;
      bit [7:0] a, d;
      ret_t r;
      if (!rst_n) begin model_reset(); return; end
      cycn++;
      m_tx_valid = 0; m_loc_rvalid = 0;
      while (rq.size() > 0 && rq[0].due == cycn) begin
         r = rq.pop_front();
         if (r.src) begin m_loc_rvalid = 1; m_loc_rdata = r.d; m_lr_known = r.k; end
         else       begin m_tx_valid = 1;   m_tx_data = r.d;   m_tx_known = r.k; end
      end
      newcmd = bus.rx_valid && bus.rx_data[8];
      s_has  = m_pend || newcmd;
      l_has  = bus.loc_req && !m_loc_gnt;
      any    = s_has || l_has;
      win_loc = (s_has && l_has) ? (m_last == 0) : l_has;
      if (win_loc) begin
         we = bus.loc_we; a = bus.loc_addr; d = bus.loc_wdata;
      end else if (m_pend) begin
         we = m_pwe; a = m_paddr; d = m_pdata;
      end else begin
         we = (bus.rx_data[9:8] == 2'b01);
         a  = we ? m_wra : m_rda;
         d  = bus.rx_data[7:0];
      end
      if (newcmd && m_pend) m_err = 1;
      if (m_pend) begin
         if (any && !win_loc) m_pend = 0;
      end else if (newcmd && win_loc) begin
         m_pend  = 1;
         m_pwe   = (bus.rx_data[9:8] == 2'b01);
         m_paddr = m_pwe ? m_wra : m_rda;
         m_pdata = bus.rx_data[7:0];
      end
      if (bus.rx_valid && bus.rx_data[9:8] == 2'b00) m_wra = bus.rx_data[7:0];
      if (bus.rx_valid && bus.rx_data[9:8] == 2'b10) m_rda = bus.rx_data[7:0];
      m_ram_en = any; m_ram_we = any && we; m_ram_addr = a; m_ram_wdata = d;
      m_loc_gnt = win_loc;
      if (any) begin
         m_last = win_loc;
         if (we) begin ref_mem[a] = d; ref_known[a] = 1; end
         else rq.push_back('{due: cycn + 2, src: win_loc, d: ref_mem[a], k: ref_known[a]});
      end
   endtask

   task automatic check_all();
      chk("ram_en", bus.ram_en, m_ram_en);
      chk("loc_gnt", bus.loc_gnt, m_loc_gnt);
      chk("tx_valid", bus.tx_valid, m_tx_valid);
      chk("loc_rvalid", bus.loc_rvalid, m_loc_rvalid);
      chk("err_ovf", bus.err_ovf, m_err);
      if (m_ram_en) begin
         chk("ram_we", bus.ram_we, m_ram_we);
         chk("ram_addr", bus.ram_addr, m_ram_addr);
         if (m_ram_we) chk("ram_wdata", bus.ram_wdata, m_ram_wdata);
      end
      if (!rst_n) begin
         chk("rst_ram_we", bus.ram_we, 0);
         chk("rst_ram_addr", bus.ram_addr, 0);
         chk("rst_ram_wdata", bus.ram_wdata, 0);
      end
      if (m_tx_known) chk("tx_data", bus.tx_data, m_tx_data);
      if (m_lr_known) chk("loc_rdata", bus.loc_rdata, m_loc_rdata);
   endtask

   // One clock: model advances, inputs for the new cycle applied, outputs checked.
   task automatic cyc(input logic rv, input logic [9:0] rd, input logic lr,
                      input logic lw, input logic [7:0] la, input logic [7:0] ld);
      @(posedge clk);
      model_step();
      #1;
      bus.rx_valid = rv; bus.rx_data = rd;
      bus.loc_req = lr; bus.loc_we = lw; bus.loc_addr = la; bus.loc_wdata = ld;
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 10'h0, 0, 0, 8'h0, 8'h0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      idle(2);
      rst_n = 1'b1;
   endtask

   function automatic logic [7:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      return (r < 8) ? 8'(r) : 8'hFF;
   endfunction

   logic       lb, lw, rv;
   logic [7:0] la, ld;
   logic [9:0] rd;

   initial begin
      bus.rx_valid = 0; bus.rx_data = 0; bus.loc_req = 0; bus.loc_we = 0;
      bus.loc_addr = 0; bus.loc_wdata = 0;
      model_reset();
      idle(3);
      chk("reset_ram_en", bus.ram_en, 0);
      chk("reset_tx_data", bus.tx_data, 0);
      chk("reset_err", bus.err_ovf, 0);
      rst_n = 1'b1;

      // 1: SPI write then read of 0x12
      cyc(1, 10'h012, 0, 0, 0, 0);
      cyc(1, 10'h1A5, 0, 0, 0, 0);
      cyc(1, 10'h212, 0, 0, 0, 0);
      chk("t1_wr_en", bus.ram_en, 1);
      cyc(1, 10'h300, 0, 0, 0, 0);
      idle(1);
      chk("t1_rd_en", bus.ram_en, 1);
      chk("t1_rd_addr", bus.ram_addr, 8'h12);
      idle(1);
      chk("t1_early", bus.tx_valid, 0);
      idle(1);
      chk("t1_tx_valid", bus.tx_valid, 1);
      chk("t1_tx_data", bus.tx_data, 8'hA5);
      idle(1);
      chk("t1_tx_pulse", bus.tx_valid, 0);

      // 2: local write 0x40 <- 3C, SPI read back
      cyc(0, 10'h0, 1, 1, 8'h40, 8'h3C);
      cyc(0, 10'h0, 1, 1, 8'h40, 8'h3C);
      chk("t2_gnt", bus.loc_gnt, 1);
      cyc(1, 10'h240, 0, 0, 0, 0);
      chk("t2_gnt_pulse", bus.loc_gnt, 0);
      cyc(1, 10'h300, 0, 0, 0, 0);
      idle(3);
      chk("t2_tx_data", bus.tx_data, 8'h3C);
      chk("t2_tx_valid", bus.tx_valid, 1);

      // 3: tie after reset goes to SPI, the following tie to local
      do_reset();
      cyc(1, 10'h212, 0, 0, 0, 0);
      cyc(1, 10'h300, 1, 0, 8'h20, 0);
      cyc(1, 10'h300, 1, 0, 8'h20, 0);
      chk("t3_spi_first", bus.loc_gnt, 0);
      chk("t3_spi_addr", bus.ram_addr, 8'h12);
      cyc(0, 10'h0, 1, 0, 8'h20, 0);
      chk("t3_loc_next", bus.loc_gnt, 1);
      chk("t3_loc_addr", bus.ram_addr, 8'h20);
      cyc(0, 10'h0, 0, 0, 0, 0);
      chk("t3_spi_again", bus.ram_en, 1);
      chk("t3_spi_again_gnt", bus.loc_gnt, 0);
      idle(3);

      // 4: second SPI write dropped while the first is still pending
      cyc(1, 10'h030, 0, 0, 0, 0);
      idle(1);
      cyc(1, 10'h111, 1, 0, 8'h31, 0);
      cyc(1, 10'h122, 1, 0, 8'h31, 0);
      chk("t4_loc_won", bus.loc_gnt, 1);
      idle(1);
      chk("t4_wdata", bus.ram_wdata, 8'h11);
      chk("t4_ovf", bus.err_ovf, 1);
      idle(2);
      cyc(1, 10'h230, 0, 0, 0, 0);
      cyc(1, 10'h300, 0, 0, 0, 0);
      idle(3);
      chk("t4_ram_kept", bus.tx_data, 8'h11);
      idle(4);
      chk("t4_ovf_sticky", bus.err_ovf, 1);

      // 5: reset lands while an SPI read is in flight
      do_reset();
      chk("t5_ovf_clr", bus.err_ovf, 0);
      cyc(1, 10'h212, 0, 0, 0, 0);
      cyc(1, 10'h300, 0, 0, 0, 0);
      idle(1);
      chk("t5_rd_en", bus.ram_en, 1);
      @(posedge clk);
      model_step();
      #3;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      check_all();
      chk("t5_en_drop", bus.ram_en, 0);
      idle(2);
      rst_n = 1'b1;
      idle(1);
      chk("t5_no_tx", bus.tx_valid, 0);
      idle(1);
      chk("t5_no_tx2", bus.tx_valid, 0);
      cyc(1, 10'h300, 1, 0, 8'h44, 0);
      cyc(0, 10'h0, 1, 0, 8'h44, 0);
      chk("t5_spi_first", bus.loc_gnt, 0);
      chk("t5_spi_en", bus.ram_en, 1);
      cyc(0, 10'h0, 1, 0, 8'h44, 0);
      chk("t5_loc_next", bus.loc_gnt, 1);
      idle(3);

      // 6: local read of the top address
      cyc(1, 10'h0FF, 0, 0, 0, 0);
      cyc(1, 10'h17E, 0, 0, 0, 0);
      idle(1);
      cyc(0, 10'h0, 1, 0, 8'hFF, 0);
      cyc(0, 10'h0, 1, 0, 8'hFF, 0);
      chk("t6_gnt", bus.loc_gnt, 1);
      chk("t6_addr", bus.ram_addr, 8'hFF);
      idle(1);
      chk("t6_early", bus.loc_rvalid, 0);
      idle(1);
      chk("t6_rvalid", bus.loc_rvalid, 1);
      chk("t6_rdata", bus.loc_rdata, 8'h7E);
      chk("t6_no_ovf", bus.err_ovf, 0);
      idle(2);

      // random traffic
      lb = 0; lw = 0; la = 0; ld = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 1000 == 999) begin do_reset(); lb = 0; end
         if (lb && m_loc_gnt) lb = 0;
         if (!lb && $urandom_range(0, 2) == 0) begin
            lb = 1; lw = 1'($urandom_range(0, 1)); la = pick_addr(); ld = 8'($urandom);
         end
         rv = ($urandom_range(0, 2) == 0);
         rd = {2'($urandom_range(0, 3)), pick_addr()};
         cyc(rv, rd, lb, lw, la, ld);
      end
      idle(4);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
